// File: rtl/mb_access_arb_if.sv
// Bundle of every signal that crosses the mb_access_arb boundary except clk/reset.
// Ports: a_* and b_* carry the two requesters' req/ack handshakes; mb_reg_* is the
//        mailbox register bank side (one-hot select, direction, write data, read mux).
// slave modport = arbiter view, master modport = requesters + mailbox view.
interface mb_access_arb_if #(
    parameter int NUMBER_INTERFACE_REGS = 16,
    parameter int ADDR_W                = 4,
    parameter int DATA_W                = 32
);
    // port A (host interface)
    logic                             a_req;
    logic                             a_rwn;
    logic [ADDR_W-1:0]                a_addr;
    logic [DATA_W-1:0]                a_wdata;
    logic                             a_ack;
    logic [DATA_W-1:0]                a_rdata;
    logic                             a_err;

    // port B (on-chip sequencer)
    logic                             b_req;
    logic                             b_rwn;
    logic [ADDR_W-1:0]                b_addr;
    logic [DATA_W-1:0]                b_wdata;
    logic                             b_ack;
    logic [DATA_W-1:0]                b_rdata;
    logic                             b_err;

    // mailbox register bank
    logic [NUMBER_INTERFACE_REGS-1:0] mb_reg_select;
    logic                             mb_reg_rwn;
    logic [DATA_W-1:0]                mb_reg_wdata;
    logic [DATA_W-1:0]                mb_reg_output;

    modport slave (
        input  a_req, a_rwn, a_addr, a_wdata,
        output a_ack, a_rdata, a_err,
        input  b_req, b_rwn, b_addr, b_wdata,
        output b_ack, b_rdata, b_err,
        output mb_reg_select, mb_reg_rwn, mb_reg_wdata,
        input  mb_reg_output
    );

    modport master (
        output a_req, a_rwn, a_addr, a_wdata,
        input  a_ack, a_rdata, a_err,
        output b_req, b_rwn, b_addr, b_wdata,
        input  b_ack, b_rdata, b_err,
        input  mb_reg_select, mb_reg_rwn, mb_reg_wdata,
        output mb_reg_output
    );
endinterface

// File: rtl/mb_access_arb.sv
// Purpose: round-robin arbiter that sequences port A / port B accesses onto the mailbox register bank.
// Latency: request seen at edge N -> ack sampled at N+2 (write), N+1+RD_LATENCY (read), N+1 (illegal).
// Backpressure: requester holds req until its one-cycle ack; the loser waits, at most one access per 3 cycles.
// Ports: clk, reset (synchronous, active-high); bus (mb_access_arb_if.slave) carrying
//        a_*/b_* req/rwn/addr/wdata in, ack/rdata/err out, and the mailbox
//        mb_reg_select/mb_reg_rwn/mb_reg_wdata out, mb_reg_output in.
module mb_access_arb #(
    parameter int NUMBER_INTERFACE_REGS = 16,
    parameter int MB_REG_START          = 3,
    parameter int VERSION_REG_ADDR      = 15,
    parameter int RD_LATENCY            = 1
) (
    input  logic           clk,
    input  logic           reset,
    mb_access_arb_if.slave bus
);

    localparam int ADDR_W = $clog2(NUMBER_INTERFACE_REGS);
    localparam int DATA_W = 32;
    localparam logic [2:0] LAST_CNT = 3'(RD_LATENCY - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_DONE   = 2'd2,
        S_ERR    = 2'd3
    } state_t;

    typedef enum logic {
        PORT_A = 1'b0,
        PORT_B = 1'b1
    } port_t;

    // state and latched request
    state_t                           state_q,    state_d;
    port_t                            rr_ptr_q,   rr_ptr_d;
    port_t                            gnt_q,      gnt_d;
    logic                             rwn_q,      rwn_d;
    logic [2:0]                       cnt_q,      cnt_d;

    // registered outputs
    logic [NUMBER_INTERFACE_REGS-1:0] sel_q,      sel_d;
    logic                             mb_rwn_q,   mb_rwn_d;
    logic [DATA_W-1:0]                mb_wdata_q, mb_wdata_d;
    logic                             a_ack_q,    a_ack_d;
    logic                             a_err_q,    a_err_d;
    logic [DATA_W-1:0]                a_rdata_q,  a_rdata_d;
    logic                             b_ack_q,    b_ack_d;
    logic                             b_err_q,    b_err_d;
    logic [DATA_W-1:0]                b_rdata_q,  b_rdata_d;

    // request selected in IDLE
    logic                             pick_b;
    logic                             in_rwn;
    logic [ADDR_W-1:0]                in_addr;
    logic [DATA_W-1:0]                in_wdata;
    logic                             illegal;

    always_comb begin
        // B wins only when A is silent or it is B's turn
        pick_b   = bus.b_req && (!bus.a_req || (rr_ptr_q == PORT_B));
        in_rwn   = pick_b ? bus.b_rwn   : bus.a_rwn;
        in_addr  = pick_b ? bus.b_addr  : bus.a_addr;
        in_wdata = pick_b ? bus.b_wdata : bus.a_wdata;
        illegal  = (int'(in_addr) <  MB_REG_START)          ||
                   (int'(in_addr) >= NUMBER_INTERFACE_REGS) ||
                   (!in_rwn && (int'(in_addr) == VERSION_REG_ADDR));

        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        gnt_d      = gnt_q;
        rwn_d      = rwn_q;
        cnt_d      = cnt_q;
        sel_d      = sel_q;
        mb_rwn_d   = mb_rwn_q;
        mb_wdata_d = mb_wdata_q;
        a_rdata_d  = a_rdata_q;
        b_rdata_d  = b_rdata_q;
        // ack and err are single-cycle pulses
        a_ack_d    = 1'b0;
        a_err_d    = 1'b0;
        b_ack_d    = 1'b0;
        b_err_d    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.a_req || bus.b_req) begin
                    gnt_d = pick_b ? PORT_B : PORT_A;
                    rwn_d = in_rwn;
                    if (illegal) begin
                        // answered straight away; the mailbox never sees it
                        state_d = S_ERR;
                        if (pick_b) begin
                            b_ack_d   = 1'b1;
                            b_err_d   = 1'b1;
                            b_rdata_d = '0;
                        end else begin
                            a_ack_d   = 1'b1;
                            a_err_d   = 1'b1;
                            a_rdata_d = '0;
                        end
                    end else begin
                        state_d    = S_ACCESS;
                        cnt_d      = '0;
                        sel_d      = NUMBER_INTERFACE_REGS'(1) << in_addr;
                        mb_rwn_d   = in_rwn;
                        mb_wdata_d = in_wdata;
                    end
                end
            end

            S_ACCESS: begin
                // writes take one cycle; reads hold select until the mux has settled
                if (!rwn_q || (cnt_q == LAST_CNT)) begin
                    state_d = S_DONE;
                    sel_d   = '0;
                    if (gnt_q == PORT_B) begin
                        b_ack_d = 1'b1;
                        if (rwn_q) begin
                            b_rdata_d = bus.mb_reg_output;
                        end
                    end else begin
                        a_ack_d = 1'b1;
                        if (rwn_q) begin
                            a_rdata_d = bus.mb_reg_output;
                        end
                    end
                end else begin
                    cnt_d = 3'(cnt_q + 3'd1);
                end
            end

            S_DONE, S_ERR: begin
                // the port just served loses the next tie
                rr_ptr_d = (gnt_q == PORT_A) ? PORT_B : PORT_A;
                state_d  = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
                sel_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            rr_ptr_q   <= PORT_A;
            gnt_q      <= PORT_A;
            rwn_q      <= 1'b1;
            cnt_q      <= '0;
            sel_q      <= '0;
            mb_rwn_q   <= 1'b1;
            mb_wdata_q <= '0;
            a_ack_q    <= 1'b0;
            a_err_q    <= 1'b0;
            a_rdata_q  <= '0;
            b_ack_q    <= 1'b0;
            b_err_q    <= 1'b0;
            b_rdata_q  <= '0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            gnt_q      <= gnt_d;
            rwn_q      <= rwn_d;
            cnt_q      <= cnt_d;
            sel_q      <= sel_d;
            mb_rwn_q   <= mb_rwn_d;
            mb_wdata_q <= mb_wdata_d;
            a_ack_q    <= a_ack_d;
            a_err_q    <= a_err_d;
            a_rdata_q  <= a_rdata_d;
            b_ack_q    <= b_ack_d;
            b_err_q    <= b_err_d;
            b_rdata_q  <= b_rdata_d;
        end
    end

    assign bus.mb_reg_select = sel_q;
    assign bus.mb_reg_rwn    = mb_rwn_q;
    assign bus.mb_reg_wdata  = mb_wdata_q;
    assign bus.a_ack         = a_ack_q;
    assign bus.a_err         = a_err_q;
    assign bus.a_rdata       = a_rdata_q;
    assign bus.b_ack         = b_ack_q;
    assign bus.b_err         = b_err_q;
    assign bus.b_rdata       = b_rdata_q;

endmodule

// File: tb/tb_mb_access_arb.sv
// Directed bench for mb_access_arb: three instances differing only in RD_LATENCY (1, 2, 3).
// Inputs are driven and outputs sampled on the falling edge; the DUT acts on the rising edge.
module tb_mb_access_arb;

    logic clk;
    logic reset;
    int   checks   = 0;
    int   errors   = 0;
    int   mon_viol = 0;

    mb_access_arb_if #(.NUMBER_INTERFACE_REGS(16)) if1 ();
    mb_access_arb_if #(.NUMBER_INTERFACE_REGS(16)) if2 ();
    mb_access_arb_if #(.NUMBER_INTERFACE_REGS(16)) if3 ();

    mb_access_arb #(.RD_LATENCY(1)) u_l1 (.clk(clk), .reset(reset), .bus(if1));
    mb_access_arb #(.RD_LATENCY(2)) u_l2 (.clk(clk), .reset(reset), .bus(if2));
    mb_access_arb #(.RD_LATENCY(3)) u_l3 (.clk(clk), .reset(reset), .bus(if3));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // every cycle: select one-hot or zero, no select below address 3, acks never together
    always @(negedge clk) begin
        if (!reset) begin
            if ((if1.mb_reg_select & (if1.mb_reg_select - 16'd1)) != 16'd0) mon_viol++;
            if ((if2.mb_reg_select & (if2.mb_reg_select - 16'd1)) != 16'd0) mon_viol++;
            if ((if3.mb_reg_select & (if3.mb_reg_select - 16'd1)) != 16'd0) mon_viol++;
            if ((if1.mb_reg_select[2:0] | if2.mb_reg_select[2:0] | if3.mb_reg_select[2:0]) != 3'b000) mon_viol++;
            if (if1.a_ack && if1.b_ack) mon_viol++;
            if (if2.a_ack && if2.b_ack) mon_viol++;
            if (if3.a_ack && if3.b_ack) mon_viol++;
        end
    end

    task automatic test_reset;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (if1.mb_reg_select !== 16'h0000) begin errors++; $display("FAIL rst_sel got %h want 0000", if1.mb_reg_select); end
        checks++; if (if1.mb_reg_rwn !== 1'b1) begin errors++; $display("FAIL rst_rwn got %b want 1", if1.mb_reg_rwn); end
        checks++; if (if1.mb_reg_wdata !== 32'h0) begin errors++; $display("FAIL rst_wdata got %h want 0", if1.mb_reg_wdata); end
        checks++; if ({if1.a_ack, if1.b_ack, if1.a_err, if1.b_err} !== 4'b0000) begin errors++; $display("FAIL rst_ack_err got %b want 0000", {if1.a_ack, if1.b_ack, if1.a_err, if1.b_err}); end
        checks++; if ({if1.a_rdata, if1.b_rdata} !== 64'h0) begin errors++; $display("FAIL rst_rdata got %h want 0", {if1.a_rdata, if1.b_rdata}); end
        checks++; if (if3.mb_reg_select !== 16'h0000) begin errors++; $display("FAIL rst_sel_l3 got %h want 0000", if3.mb_reg_select); end
        reset = 1'b0;
    endtask

    // A writes 0xDEADBEEF to address 5 on the RD_LATENCY=1 instance
    task automatic test_write_a;
        if1.a_req = 1'b1; if1.a_rwn = 1'b0; if1.a_addr = 4'd5; if1.a_wdata = 32'hDEADBEEF;
        @(negedge clk);
        checks++; if (if1.mb_reg_select !== 16'h0020) begin errors++; $display("FAIL wr_sel got %h want 0020", if1.mb_reg_select); end
        checks++; if (if1.mb_reg_rwn !== 1'b0) begin errors++; $display("FAIL wr_rwn got %b want 0", if1.mb_reg_rwn); end
        checks++; if (if1.mb_reg_wdata !== 32'hDEADBEEF) begin errors++; $display("FAIL wr_wdata got %h want deadbeef", if1.mb_reg_wdata); end
        checks++; if (if1.a_ack !== 1'b0) begin errors++; $display("FAIL wr_early_ack got %b want 0", if1.a_ack); end
        @(negedge clk);
        checks++; if (if1.mb_reg_select !== 16'h0000) begin errors++; $display("FAIL wr_sel_done got %h want 0000", if1.mb_reg_select); end
        checks++; if ({if1.a_ack, if1.a_err, if1.b_ack} !== 3'b100) begin errors++; $display("FAIL wr_ack got ack/err/back %b want 100", {if1.a_ack, if1.a_err, if1.b_ack}); end
        if1.a_req = 1'b0;
        @(negedge clk);
        checks++; if (if1.a_ack !== 1'b0) begin errors++; $display("FAIL wr_ack_pulse got %b want 0", if1.a_ack); end
    endtask

    // B reads the version register on the RD_LATENCY=2 instance
    task automatic test_read_b;
        if2.mb_reg_output = 32'h00010203;
        if2.b_req = 1'b1; if2.b_rwn = 1'b1; if2.b_addr = 4'd15; if2.b_wdata = 32'h0;
        for (int c = 1; c <= 2; c++) begin
            @(negedge clk);
            checks++; if (if2.mb_reg_select !== 16'h8000) begin errors++; $display("FAIL rd_sel_c%0d got %h want 8000", c, if2.mb_reg_select); end
            checks++; if (if2.b_ack !== 1'b0) begin errors++; $display("FAIL rd_early_ack_c%0d got %b want 0", c, if2.b_ack); end
        end
        @(negedge clk);
        checks++; if (if2.mb_reg_select !== 16'h0000) begin errors++; $display("FAIL rd_sel_done got %h want 0000", if2.mb_reg_select); end
        checks++; if ({if2.b_ack, if2.b_err, if2.a_ack} !== 3'b100) begin errors++; $display("FAIL rd_ack got ack/err/aack %b want 100", {if2.b_ack, if2.b_err, if2.a_ack}); end
        checks++; if (if2.b_rdata !== 32'h00010203) begin errors++; $display("FAIL rd_rdata got %h want 00010203", if2.b_rdata); end
        if2.b_req = 1'b0;
        @(negedge clk);
        checks++; if (if2.b_ack !== 1'b0) begin errors++; $display("FAIL rd_ack_pulse got %b want 0", if2.b_ack); end
    endtask

    // A reads address 3 (sets rdata), then writes the version register, then reads address 2
    task automatic test_read_and_errors;
        if1.mb_reg_output = 32'hCAFE0001;
        if1.a_req = 1'b1; if1.a_rwn = 1'b1; if1.a_addr = 4'd3;
        @(negedge clk);
        checks++; if (if1.mb_reg_select !== 16'h0008) begin errors++; $display("FAIL rd3_sel got %h want 0008", if1.mb_reg_select); end
        @(negedge clk);
        checks++; if ({if1.a_ack, if1.a_err} !== 2'b10) begin errors++; $display("FAIL rd3_ack got ack/err %b want 10", {if1.a_ack, if1.a_err}); end
        checks++; if (if1.a_rdata !== 32'hCAFE0001) begin errors++; $display("FAIL rd3_rdata got %h want cafe0001", if1.a_rdata); end
        if1.a_req = 1'b0;
        if1.mb_reg_output = 32'h55555555;
        @(negedge clk);
        checks++; if (if1.a_rdata !== 32'hCAFE0001) begin errors++; $display("FAIL rdata_hold got %h want cafe0001", if1.a_rdata); end
        // write to the read-only version register
        if1.a_req = 1'b1; if1.a_rwn = 1'b0; if1.a_addr = 4'd15; if1.a_wdata = 32'h11112222;
        @(negedge clk);
        checks++; if ({if1.a_ack, if1.a_err} !== 2'b11) begin errors++; $display("FAIL err_ver_ack got ack/err %b want 11", {if1.a_ack, if1.a_err}); end
        checks++; if (if1.a_rdata !== 32'h0) begin errors++; $display("FAIL err_ver_rdata got %h want 0", if1.a_rdata); end
        checks++; if (if1.mb_reg_select !== 16'h0000) begin errors++; $display("FAIL err_ver_sel got %h want 0000", if1.mb_reg_select); end
        if1.a_req = 1'b0;
        @(negedge clk);
        checks++; if ({if1.a_ack, if1.a_err, if1.mb_reg_select} !== 18'h0) begin errors++; $display("FAIL err_ver_after got %h want 0", {if1.a_ack, if1.a_err, if1.mb_reg_select}); end
        // read below the first legal register
        if1.a_req = 1'b1; if1.a_rwn = 1'b1; if1.a_addr = 4'd2;
        @(negedge clk);
        checks++; if ({if1.a_ack, if1.a_err} !== 2'b11) begin errors++; $display("FAIL err_low_ack got ack/err %b want 11", {if1.a_ack, if1.a_err}); end
        checks++; if (if1.mb_reg_select !== 16'h0000) begin errors++; $display("FAIL err_low_sel got %h want 0000", if1.mb_reg_select); end
        if1.a_req = 1'b0;
        @(negedge clk);
        checks++; if (if1.a_ack !== 1'b0) begin errors++; $display("FAIL err_low_pulse got %b want 0", if1.a_ack); end
    endtask

    // both requesters held high from reset: grants alternate A, B, A, B
    task automatic test_round_robin;
        logic order [4];
        logic exp_order [4];
        int   n_ack = 0;
        int   both  = 0;
        exp_order[0] = 1'b0; exp_order[1] = 1'b1; exp_order[2] = 1'b0; exp_order[3] = 1'b1;
        for (int i = 0; i < 4; i++) order[i] = 1'bx;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        if1.a_req = 1'b1; if1.a_rwn = 1'b0; if1.a_addr = 4'd4; if1.a_wdata = 32'hA0A0A0A0;
        if1.b_req = 1'b1; if1.b_rwn = 1'b0; if1.b_addr = 4'd6; if1.b_wdata = 32'hB0B0B0B0;
        for (int c = 0; c < 40 && n_ack < 4; c++) begin
            @(negedge clk);
            if (if1.a_ack && if1.b_ack) both++;
            if (if1.a_ack) begin order[n_ack] = 1'b0; n_ack++; end
            else if (if1.b_ack) begin order[n_ack] = 1'b1; n_ack++; end
        end
        if1.a_req = 1'b0; if1.b_req = 1'b0;
        @(negedge clk);
        checks++; if (n_ack !== 4) begin errors++; $display("FAIL rr_ack_count got %0d want 4", n_ack); end
        for (int i = 0; i < 4; i++) begin
            checks++; if (order[i] !== exp_order[i]) begin errors++; $display("FAIL rr_order_%0d got port %b want port %b (0=A 1=B)", i, order[i], exp_order[i]); end
        end
        checks++; if (both !== 0) begin errors++; $display("FAIL rr_ack_coincide got %0d want 0", both); end
    endtask

    // reset during the second ACCESS cycle of a RD_LATENCY=3 read, then a clean read
    task automatic test_reset_mid;
        int acks = 0;
        if3.mb_reg_output = 32'h0BADF00D;
        if3.a_req = 1'b1; if3.a_rwn = 1'b1; if3.a_addr = 4'd7;
        @(negedge clk);
        checks++; if (if3.mb_reg_select !== 16'h0080) begin errors++; $display("FAIL rm_sel got %h want 0080", if3.mb_reg_select); end
        @(negedge clk);
        reset = 1'b1;
        if3.a_req = 1'b0;
        @(negedge clk);
        checks++; if ({if3.mb_reg_select, if3.a_ack, if3.a_err} !== 18'h0) begin errors++; $display("FAIL rm_abort got sel/ack/err %h want 0", {if3.mb_reg_select, if3.a_ack, if3.a_err}); end
        reset = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (if3.a_ack || if3.b_ack) acks++;
        end
        checks++; if (acks !== 0) begin errors++; $display("FAIL rm_stray_ack got %0d want 0", acks); end
        if3.mb_reg_output = 32'h12345678;
        if3.a_req = 1'b1;
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            checks++; if ({if3.mb_reg_select, if3.a_ack} !== {16'h0080, 1'b0}) begin errors++; $display("FAIL rm_fresh_c%0d got sel/ack %h want 00100", c, {if3.mb_reg_select, if3.a_ack}); end
        end
        @(negedge clk);
        checks++; if ({if3.a_ack, if3.a_err} !== 2'b10) begin errors++; $display("FAIL rm_fresh_ack got ack/err %b want 10", {if3.a_ack, if3.a_err}); end
        checks++; if (if3.a_rdata !== 32'h12345678) begin errors++; $display("FAIL rm_fresh_rdata got %h want 12345678", if3.a_rdata); end
        if3.a_req = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b1;
        if1.a_req = 1'b0; if1.a_rwn = 1'b1; if1.a_addr = '0; if1.a_wdata = '0;
        if1.b_req = 1'b0; if1.b_rwn = 1'b1; if1.b_addr = '0; if1.b_wdata = '0;
        if1.mb_reg_output = '0;
        if2.a_req = 1'b0; if2.a_rwn = 1'b1; if2.a_addr = '0; if2.a_wdata = '0;
        if2.b_req = 1'b0; if2.b_rwn = 1'b1; if2.b_addr = '0; if2.b_wdata = '0;
        if2.mb_reg_output = '0;
        if3.a_req = 1'b0; if3.a_rwn = 1'b1; if3.a_addr = '0; if3.a_wdata = '0;
        if3.b_req = 1'b0; if3.b_rwn = 1'b1; if3.b_addr = '0; if3.b_wdata = '0;
        if3.mb_reg_output = '0;

        test_reset;
        test_write_a;
        test_read_b;
        test_read_and_errors;
        test_round_robin;
        test_reset_mid;

        checks++; if (mon_viol !== 0) begin errors++; $display("FAIL monitor_onehot_ack got %0d violations want 0", mon_viol); end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
